// File: rtl/viterbi_pkg.sv
// Shared definitions for the soft-decision Viterbi datapath.
//   soft_max()  : largest soft symbol value for a given symbol width
//   bm_width()  : width needed to hold a branch metric of N_OUT symbols
//   DEC_EDGE1/2 : encoding of the survivor decision bit
package viterbi_pkg;

  localparam int SOFT_W_DEF = 3;

  function automatic int soft_max(input int soft_w);
    return (1 << soft_w) - 1;
  endfunction

  localparam int SOFT_MAX = soft_max(SOFT_W_DEF);

  // N_OUT symbols of at most 2^SOFT_W-1 each sum to less than 2^(SOFT_W+clog2(N_OUT)).
  function automatic int bm_width(input int n_out, input int soft_w);
    return soft_w + $clog2(n_out);
  endfunction

  localparam logic DEC_EDGE1 = 1'b0;
  localparam logic DEC_EDGE2 = 1'b1;

endpackage

// File: rtl/acs_unit_soft_if.sv
// Handshake/data bundle between the decoder controller (master) and one
// ACS state unit (slave).
//   start, in_valid, norm_en        : control from the controller
//   rx_sym, exp_1/2, pm_in_1/2      : soft symbols, expected codewords, predecessor metrics
//   pm_out, dec_out, out_valid      : registered survivor result
//   norm_req, sat_err               : status back to the controller
interface acs_unit_soft_if #(
  parameter int N_OUT  = 2,
  parameter int SOFT_W = 3,
  parameter int PM_W   = 8
);
  logic                      start;
  logic                      in_valid;
  logic [N_OUT*SOFT_W-1:0]   rx_sym;
  logic [N_OUT-1:0]          exp_1;
  logic [N_OUT-1:0]          exp_2;
  logic [PM_W-1:0]           pm_in_1;
  logic [PM_W-1:0]           pm_in_2;
  logic                      norm_en;
  logic [PM_W-1:0]           pm_out;
  logic                      dec_out;
  logic                      out_valid;
  logic                      norm_req;
  logic                      sat_err;

  modport master (
    output start, in_valid, rx_sym, exp_1, exp_2, pm_in_1, pm_in_2, norm_en,
    input  pm_out, dec_out, out_valid, norm_req, sat_err
  );

  modport slave (
    input  start, in_valid, rx_sym, exp_1, exp_2, pm_in_1, pm_in_2, norm_en,
    output pm_out, dec_out, out_valid, norm_req, sat_err
  );
endinterface

// File: rtl/branch_metric_soft.sv
// Soft-decision branch metric for one trellis edge: the distance between the
// received soft symbols and an expected codeword. A symbol expected as '1'
// costs (max - rx), one expected as '0' costs rx. With SOFT_W=1 this reduces
// to the hard-decision Hamming distance.
//   rx_sym_i : N_OUT soft symbols, symbol i at [i*SOFT_W +: SOFT_W]
//   exp_i    : expected codeword bits
//   bm_o     : branch metric
module branch_metric_soft
  import viterbi_pkg::*;
#(
  parameter int N_OUT  = 2,
  parameter int SOFT_W = 3,
  parameter int BM_W   = bm_width(N_OUT, SOFT_W)
) (
  input  logic [N_OUT*SOFT_W-1:0] rx_sym_i,
  input  logic [N_OUT-1:0]        exp_i,
  output logic [BM_W-1:0]         bm_o
);

  localparam logic [SOFT_W-1:0] SMAX = SOFT_W'(soft_max(SOFT_W));

  logic [N_OUT-1:0][SOFT_W-1:0] cost;

  for (genvar i = 0; i < N_OUT; i++) begin : g_sym
    assign cost[i] = exp_i[i] ? (SMAX - rx_sym_i[i*SOFT_W +: SOFT_W])
                              : rx_sym_i[i*SOFT_W +: SOFT_W];
  end

  always_comb begin
    bm_o = '0;
    for (int i = 0; i < N_OUT; i++) bm_o = bm_o + BM_W'(cost[i]);
  end

endmodule

// File: rtl/acs_unit_soft.sv
// Registered add-compare-select unit for one trellis state.
// Adds a soft branch metric to each predecessor metric, clamps to the metric
// range (flagging saturation), picks the survivor and registers it.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of acs_unit_soft_if (inputs, survivor metric,
//                decision, valid, normalisation request, sticky saturation)
module acs_unit_soft
  import viterbi_pkg::*;
#(
  parameter int N_OUT       = 2,
  parameter int SOFT_W      = 3,
  parameter int PM_W        = 8,
  parameter bit IS_ROOT     = 1'b0,
  parameter int INIT_PM     = 64,
  parameter int NORM_SUB    = 128,
  parameter int NORM_THRESH = 192
) (
  input  logic           clk,
  input  logic           rst_n,
  acs_unit_soft_if.slave bus
);

  localparam int BM_W = bm_width(N_OUT, SOFT_W);
  // Candidate width wide enough that pm + bm never wraps before the clamp.
  localparam int CW   = ((PM_W > BM_W) ? PM_W : BM_W) + 1;
  localparam logic [PM_W-1:0] PM_MAX  = '1;
  localparam logic [PM_W-1:0] PM_INIT = IS_ROOT ? '0 : PM_W'(INIT_PM);
  localparam logic [PM_W-1:0] PM_SUB  = PM_W'(NORM_SUB);

  logic [BM_W-1:0] bm_1, bm_2;

  branch_metric_soft #(.N_OUT(N_OUT), .SOFT_W(SOFT_W), .BM_W(BM_W)) u_bm_1 (
    .rx_sym_i (bus.rx_sym),
    .exp_i    (bus.exp_1),
    .bm_o     (bm_1)
  );

  branch_metric_soft #(.N_OUT(N_OUT), .SOFT_W(SOFT_W), .BM_W(BM_W)) u_bm_2 (
    .rx_sym_i (bus.rx_sym),
    .exp_i    (bus.exp_2),
    .bm_o     (bm_2)
  );

  logic [CW-1:0]   sum_1, sum_2;
  logic            ovf_1, ovf_2;
  logic [PM_W-1:0] cand_1, cand_2, win;
  logic            pick_2;

  assign sum_1  = CW'(bus.pm_in_1) + CW'(bm_1);
  assign sum_2  = CW'(bus.pm_in_2) + CW'(bm_2);
  assign ovf_1  = sum_1 > CW'(PM_MAX);
  assign ovf_2  = sum_2 > CW'(PM_MAX);
  assign cand_1 = ovf_1 ? PM_MAX : sum_1[PM_W-1:0];
  assign cand_2 = ovf_2 ? PM_MAX : sum_2[PM_W-1:0];

  // Ties on the clamped candidate go to the smaller branch metric, then edge 1.
  assign pick_2 = (cand_2 < cand_1) || ((cand_2 == cand_1) && (bm_2 < bm_1));
  assign win    = pick_2 ? cand_2 : cand_1;

  logic [PM_W-1:0] pm_q, pm_d;
  logic            dec_q, dec_d;
  logic            ov_q, ov_d;
  logic            sat_q, sat_d;

  always_comb begin
    pm_d  = pm_q;
    dec_d = dec_q;
    ov_d  = 1'b0;
    sat_d = sat_q;
    if (bus.start) begin
      // New block: valid data in the same cycle is dropped.
      pm_d  = PM_INIT;
      dec_d = DEC_EDGE1;
      sat_d = 1'b0;
    end else if (bus.in_valid) begin
      ov_d  = 1'b1;
      dec_d = pick_2 ? DEC_EDGE2 : DEC_EDGE1;
      sat_d = sat_q | ovf_1 | ovf_2;
      if (bus.norm_en) pm_d = (win >= PM_SUB) ? (win - PM_SUB) : '0;
      else             pm_d = win;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pm_q  <= PM_INIT;
      dec_q <= DEC_EDGE1;
      ov_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      pm_q  <= pm_d;
      dec_q <= dec_d;
      ov_q  <= ov_d;
      sat_q <= sat_d;
    end
  end

  assign bus.pm_out    = pm_q;
  assign bus.dec_out   = dec_q;
  assign bus.out_valid = ov_q;
  assign bus.sat_err   = sat_q;
  assign bus.norm_req  = (int'(pm_q) >= NORM_THRESH);

endmodule

// File: tb/tb_acs_unit_soft.sv
module tb_acs_unit_soft;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acs_unit_soft_if #(.N_OUT(2), .SOFT_W(3), .PM_W(8)) bd ();
  acs_unit_soft_if #(.N_OUT(2), .SOFT_W(3), .PM_W(8)) br ();

  // Root instance sees the same stimulus as the default one.
  assign br.start    = bd.start;
  assign br.in_valid = bd.in_valid;
  assign br.rx_sym   = bd.rx_sym;
  assign br.exp_1    = bd.exp_1;
  assign br.exp_2    = bd.exp_2;
  assign br.pm_in_1  = bd.pm_in_1;
  assign br.pm_in_2  = bd.pm_in_2;
  assign br.norm_en  = bd.norm_en;

  acs_unit_soft #(.IS_ROOT(1'b0)) dut_d (.clk(clk), .rst_n(rst_n), .bus(bd));
  acs_unit_soft #(.IS_ROOT(1'b1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(br));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_d(input string tag, input int pm, input bit dec, input bit ov,
                       input bit nr, input bit sat);
    chk({tag, ".pm"},  int'(bd.pm_out),    pm);
    chk({tag, ".dec"}, int'(bd.dec_out),   int'(dec));
    chk({tag, ".ov"},  int'(bd.out_valid), int'(ov));
    chk({tag, ".nr"},  int'(bd.norm_req),  int'(nr));
    chk({tag, ".sat"}, int'(bd.sat_err),   int'(sat));
  endtask

  task automatic chk_r(input string tag, input int pm, input bit dec, input bit ov,
                       input bit nr, input bit sat);
    chk({tag, ".pm"},  int'(br.pm_out),    pm);
    chk({tag, ".dec"}, int'(br.dec_out),   int'(dec));
    chk({tag, ".ov"},  int'(br.out_valid), int'(ov));
    chk({tag, ".nr"},  int'(br.norm_req),  int'(nr));
    chk({tag, ".sat"}, int'(br.sat_err),   int'(sat));
  endtask

  // ---------------- reference model ----------------
  typedef struct { int pm; bit dec; bit ov; bit sat; } st_t;

  function automatic int bmf(input logic [5:0] rx, input logic [1:0] e);
    int s;
    int sym;
    s = 0;
    for (int i = 0; i < 2; i++) begin
      sym = int'(rx[i*3 +: 3]);
      s += e[i] ? (7 - sym) : sym;
    end
    return s;
  endfunction

  function automatic st_t step(input st_t s, input bit rn, input bit st, input bit v,
                               input logic [5:0] rx, input logic [1:0] e1, input logic [1:0] e2,
                               input int p1, input int p2, input bit nm, input bit root);
    st_t n;
    int b1, b2, c1, c2, w;
    n = s;
    n.ov = 1'b0;
    if (!rn || st) begin
      n.pm = root ? 0 : 64;
      n.dec = 1'b0;
      n.sat = 1'b0;
      return n;
    end
    if (!v) return n;
    b1 = bmf(rx, e1);
    b2 = bmf(rx, e2);
    c1 = p1 + b1;
    c2 = p2 + b2;
    if (c1 > 255 || c2 > 255) n.sat = 1'b1;
    if (c1 > 255) c1 = 255;
    if (c2 > 255) c2 = 255;
    if (c1 < c2 || (c1 == c2 && b1 <= b2)) begin w = c1; n.dec = 1'b0; end
    else begin w = c2; n.dec = 1'b1; end
    if (nm) w = (w >= 128) ? w - 128 : 0;
    n.pm = w;
    n.ov = 1'b1;
    return n;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit st; bit v; logic [5:0] rx; logic [1:0] e1; logic [1:0] e2;
    int p1; int p2; bit nm;
    int pm; bit dec; bit ov; bit nr; bit sat;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input bit st, input bit v, input logic [5:0] rx, input logic [1:0] e1,
                       input logic [1:0] e2, input int p1, input int p2, input bit nm);
    bd.start = st; bd.in_valid = v; bd.rx_sym = rx; bd.exp_1 = e1; bd.exp_2 = e2;
    bd.pm_in_1 = 8'(p1); bd.pm_in_2 = 8'(p2); bd.norm_en = nm;
  endtask

  initial begin
    st_t sd, sr;
    bit rn, st, v, nm;
    logic [5:0] rx;
    logic [1:0] e1, e2;
    int p1, p2;

    //                st v  rx     e1     e2     p1  p2  nm    pm dec ov nr sat
    tbl.push_back('{0, 1, 6'o07, 2'b01, 2'b10, 10, 10, 0,   10, 0, 1, 0, 0}); // clear winner
    tbl.push_back('{0, 1, 6'o04, 2'b00, 2'b01, 20, 21, 0,   24, 1, 1, 0, 0}); // tie -> smaller bm
    tbl.push_back('{0, 0, 6'o04, 2'b00, 2'b01, 20, 21, 0,   24, 1, 0, 0, 0}); // stall holds dec=1
    tbl.push_back('{0, 1, 6'o04, 2'b00, 2'b00, 20, 21, 0,   24, 0, 1, 0, 0}); // exp_2=00
    tbl.push_back('{0, 1, 6'o04, 2'b00, 2'b00, 30, 30, 0,   34, 0, 1, 0, 0}); // full tie -> edge 1
    tbl.push_back('{0, 1, 6'o07, 2'b10, 2'b01, 10, 10, 0,   10, 1, 1, 0, 0}); // edge 2 wins
    tbl.push_back('{0, 1, 6'o07, 2'b01, 2'b10, 191, 191, 0, 191, 0, 1, 0, 0}); // below threshold
    tbl.push_back('{0, 1, 6'o07, 2'b01, 2'b10, 192, 192, 0, 192, 0, 1, 1, 0}); // at threshold
    tbl.push_back('{0, 1, 6'o77, 2'b00, 2'b00, 250, 250, 0, 255, 0, 1, 1, 1}); // saturation
    tbl.push_back('{0, 1, 6'o07, 2'b01, 2'b10, 10, 10, 0,   10, 0, 1, 0, 1}); // sat sticky
    tbl.push_back('{0, 1, 6'o07, 2'b01, 2'b10, 200, 200, 1, 72, 0, 1, 0, 1}); // normalise
    tbl.push_back('{0, 1, 6'o07, 2'b01, 2'b10, 100, 100, 1,  0, 0, 1, 0, 1}); // floor at 0
    tbl.push_back('{0, 1, 6'o07, 2'b01, 2'b10, 128, 128, 1,  0, 0, 1, 0, 1}); // exact sub
    tbl.push_back('{0, 1, 6'o07, 2'b01, 2'b10, 129, 129, 1,  1, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 6'o77, 2'b00, 2'b00, 250, 250, 0,  1, 0, 0, 0, 1}); // stall x3
    tbl.push_back('{0, 0, 6'o77, 2'b00, 2'b00, 250, 250, 0,  1, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 6'o77, 2'b00, 2'b00, 250, 250, 0,  1, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 6'o07, 2'b01, 2'b10, 10, 10, 0,   64, 0, 0, 0, 0}); // start beats valid
    tbl.push_back('{0, 1, 6'o07, 2'b01, 2'b10, 255, 0, 0,   14, 1, 1, 0, 0}); // 255 no sat
    tbl.push_back('{1, 0, 6'o07, 2'b01, 2'b10, 10, 10, 0,   64, 0, 0, 0, 0}); // start alone

    // Reset
    drive(0, 0, '0, '0, '0, 0, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_d("rst_d", 64, 0, 0, 0, 0);
    chk_r("rst_r", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Directed table
    foreach (tbl[k]) begin
      drive(tbl[k].st, tbl[k].v, tbl[k].rx, tbl[k].e1, tbl[k].e2, tbl[k].p1, tbl[k].p2, tbl[k].nm);
      @(posedge clk); #1;
      chk_d($sformatf("vec%0d", k), tbl[k].pm, tbl[k].dec, tbl[k].ov, tbl[k].nr, tbl[k].sat);
    end

    // Mid-block reset overrides start and valid; root reloads 0.
    drive(0, 1, 6'o77, 2'b00, 2'b00, 250, 250, 0);
    @(posedge clk); #1;
    chk_d("pre_rst_d", 255, 0, 1, 1, 1);
    chk_r("pre_rst_r", 255, 0, 1, 1, 1);
    drive(1, 1, 6'o07, 2'b01, 2'b10, 10, 10, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_d("mid_rst_d", 64, 0, 0, 0, 0);
    chk_r("mid_rst_r", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Randomised run against the model, both instances
    sd = '{64, 1'b0, 1'b0, 1'b0};
    sr = '{0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 500; c++) begin
      rn = ($urandom_range(0, 59) != 0);
      st = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 3) != 0);
      nm = ($urandom_range(0, 7) == 0);
      rx = 6'($urandom);
      e1 = 2'($urandom);
      e2 = 2'($urandom);
      p1 = ($urandom_range(0, 3) == 0) ? $urandom_range(230, 255) : $urandom_range(0, 255);
      p2 = ($urandom_range(0, 3) == 0) ? p1 + $urandom_range(0, 3) - 1 : $urandom_range(0, 255);
      if (p2 < 0) p2 = 0;
      if (p2 > 255) p2 = 255;
      rst_n = rn;
      drive(st, v, rx, e1, e2, p1, p2, nm);
      sd = step(sd, rn, st, v, rx, e1, e2, p1, p2, nm, 1'b0);
      sr = step(sr, rn, st, v, rx, e1, e2, p1, p2, nm, 1'b1);
      @(posedge clk); #1;
      chk_d($sformatf("rnd%0d_d", c), sd.pm, sd.dec, sd.ov, sd.pm >= 192, sd.sat);
      chk_r($sformatf("rnd%0d_r", c), sr.pm, sr.dec, sr.ov, sr.pm >= 192, sr.sat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acs_unit_soft.md
Name: acs_unit_soft

Overview:
- Parametrised, registered add-compare-select unit: the next generation of the combinational ACS used in the PipeViterbi trellis.
- Computes soft-decision branch metrics for both incoming trellis edges and selects the survivor.
- Registers the survivor path metric and decision bit with a valid handshake.
- Supports start/initialisation, saturation detection and globally coordinated metric normalisation.
- One instance per trellis state; the decoder top-level supplies the predecessor metrics and expected codewords.

Parameters:
- N_OUT, 2: coded bits per trellis branch (code rate 1/N_OUT).
- SOFT_W, 3: bits per soft symbol; 0 = strong '0', 2^SOFT_W-1 = strong '1'.
- PM_W, 8: path metric width.
- IS_ROOT, 0: 1 = this state is the trellis start state.
- INIT_PM, 64: metric loaded into non-root states on reset/start; root loads 0.
- NORM_SUB, 128: value subtracted on normalisation.
- NORM_THRESH, 192: pm_out at or above this raises norm_req.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; re-initialises the metric for a new block
- in_valid  in  1  inputs valid this cycle
- rx_sym  in  N_OUT*SOFT_W  soft symbols; symbol i at [i*SOFT_W +: SOFT_W]
- exp_1  in  N_OUT  expected codeword, edge 1
- exp_2  in  N_OUT  expected codeword, edge 2
- pm_in_1  in  PM_W  predecessor metric, edge 1
- pm_in_2  in  PM_W  predecessor metric, edge 2
- norm_en  in  1  global normalise command, identical at all instances
- pm_out  out  PM_W  registered survivor metric
- dec_out  out  1  registered decision: 0 = edge 1, 1 = edge 2
- out_valid  out  1  pm_out/dec_out updated this cycle
- norm_req  out  1  pm_out >= NORM_THRESH (combinational from register)
- sat_err  out  1  sticky: a candidate metric saturated

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: pm_out = IS_ROOT ? 0 : INIT_PM; dec_out = 0; out_valid = 0; sat_err = 0. norm_req follows from pm_out.
- Branch metric per edge k: bm_k = sum over i of (exp_k[i] ? (2^SOFT_W-1 - rx_i) : rx_i).
  - Width BM_W = SOFT_W + clog2(N_OUT); default 4, maximum 14.
- Candidate metrics: cand_k = pm_in_k + bm_k, computed at PM_W+1 bits.
  - If cand_k exceeds 2^PM_W-1, clamp it to 2^PM_W-1 and set sat_err.
- Select rule:
  - cand_1 < cand_2: pick edge 1.
  - cand_1 > cand_2: pick edge 2.
  - Equal: pick the edge with the smaller bm; if bm also equal, pick edge 1.
- Normalisation: if norm_en is high with in_valid, the winner minus NORM_SUB is stored, floored at 0. The floor is a sizing error but must not wrap.
- Latency: 1 cycle. in_valid at edge t gives pm_out, dec_out and out_valid=1 after edge t.
- Stall: in_valid=0 (and no start) holds pm_out, dec_out and sat_err; out_valid=0.
- Start priority: start takes precedence over in_valid in the same cycle.
  - Loads the reset metric; dec_out=0, out_valid=0, sat_err cleared.
  - Valid inputs in that cycle are discarded.
- Reset priority: rst_n low overrides start and in_valid, including mid-block.
- No internal state machine beyond the registers. Block-level sequencing is owned by the decoder controller.

Decomposition:
- Package viterbi_pkg holds:
  - soft-symbol max constant;
  - BM_W derivation function;
  - decision encoding constants DEC_EDGE1=0, DEC_EDGE2=1.
- Sub-module branch_metric_soft (parameters N_OUT, SOFT_W) computes one bm; instantiate twice. It generalises the hard-decision Hamming-distance compute.
- The ACS compare/select and its registers stay in acs_unit_soft.

Test Plan:
- Reset: rst_n=0 for one edge, defaults -> pm_out=64, dec_out=0, out_valid=0, norm_req=0, sat_err=0. With IS_ROOT=1 -> pm_out=0.
- Clear winner: rx_sym = {sym1=0, sym0=7}, exp_1=2'b01, exp_2=2'b10, pm_in_1=pm_in_2=10.
  - bm_1=0, bm_2=14.
  - Next cycle: pm_out=10, dec_out=0, out_valid=1.
- Tie-break: rx={0,4}, exp_1=2'b00, exp_2=2'b01, pm_in_1=20, pm_in_2=21.
  - bm_1=4, bm_2=3, both candidates 24.
  - Result: pm_out=24, dec_out=1.
  - Repeat with exp_2=2'b00 -> dec_out=0.
- Saturation: pm_in_1=pm_in_2=250, bm_1=bm_2=14.
  - Result: pm_out=255, dec_out=0, sat_err=1, norm_req=1.
  - sat_err stays 1 through later valid cycles until start.
- Normalise: winner 200 with norm_en=1 -> pm_out=72, norm_req=0.
  - Winner 100 with norm_en=1 -> pm_out=0 (no wrap).
- Stall/start: in_valid=0 for 3 cycles -> pm_out held, out_valid=0.
  - start=1 together with in_valid=1 -> pm_out=64, out_valid=0, sat_err=0.
